gpio_in_debounce: RTL
=====================

# gpio_in_debounce

Input-conditioning stage in front of the CoreGPIO `GPIO_IN` bus. It synchronises up to 32 asynchronous board-level inputs into the `SYSCLK_apb` domain and debounces each bit against a programmable number of prescaled sample ticks. It drives the stable result onto `GPIO_IN`, so CoreGPIO edge and level interrupts only ever see clean transitions. Per-bit rise/fall event pulses are also produced for local status logic.

## Interface
Parameters:
- `IO_NUM`, 8: number of inputs, legal range 1..32.
- `SYNC_STAGES`, 2: synchroniser depth, legal range 2..4.
- `CNT_WIDTH`, 4: width of each per-bit debounce counter and of `THRESH`.
- `PRESCALE`, 100: `SYSCLK_apb` cycles per sample tick, legal range 1..65535.

Ports:
- `SYSCLK_apb`, in, 1: clock.
- `PRESETN`, in, 1: reset, asynchronous, active-low.
- `EN`, in, 1: debounce enable. When 0, the block runs in bypass mode.
- `RAW_IN`, in, `IO_NUM`: asynchronous external inputs.
- `THRESH`, in, `CNT_WIDTH`: number of consecutive mismatching ticks needed to accept a new level. A value of 0 is treated as 1. Quasi-static.
- `GPIO_IN_DB`, out, `IO_NUM`: debounced levels, connected to CoreGPIO `GPIO_IN`.
- `RISE`, out, `IO_NUM`: one-cycle pulse per bit on an accepted 0→1 change.
- `FALL`, out, `IO_NUM`: one-cycle pulse per bit on an accepted 1→0 change.
- `TICK`, out, 1: one-cycle prescaler tick, exported for observation.

## Operation
Synchroniser:
- Each bit passes through a `SYNC_STAGES`-deep flop chain.
- `sync[i]` is the last stage of that chain. All stages reset to 0.

Prescaler:
- Counter `pcnt` runs 0..`PRESCALE`-1, then wraps to 0.
- `TICK` = 1 in the cycle where `pcnt` == `PRESCALE`-1.
- If `PRESCALE` = 1, `TICK` is asserted every cycle.
- When `EN` = 0, `pcnt` is held at 0 and `TICK` = 0.

Per-bit debounce, with state `stable[i]` (drives `GPIO_IN_DB[i]`) and `cnt[i]`:
- `sync[i]` == `stable[i]`: `cnt[i]` ← 0 in every cycle, whether or not there is a tick.
- `sync[i]` != `stable[i]`, no tick: `cnt[i]` holds.
- `sync[i]` != `stable[i]`, tick, and `cnt[i]`+1 >= THRESH_eff (where THRESH_eff = max(`THRESH`, 1)):
  - `stable[i]` ← `sync[i]` and `cnt[i]` ← 0.
  - `RISE[i]` or `FALL[i]` is registered high for exactly one cycle.
- Otherwise (mismatch, tick, threshold not reached): `cnt[i]` ← `cnt[i]`+1.
- The compare uses >=, so lowering `THRESH` mid-count never strands a counter. Counters never exceed 2^`CNT_WIDTH`-1.

Bypass mode (`EN` = 0):
- All `cnt` are cleared.
- `stable[i]` ← `sync[i]` every cycle.
- `RISE`/`FALL` still pulse on every change.

`EN` transitions:
- 1→0: any pending qualification is abandoned.
- 0→1: qualification starts from `cnt` = 0 and `pcnt` = 0.

Other rules:
- Bits are fully independent. Simultaneous changes on several bits update in the same cycle.
- `RISE[i]` and `FALL[i]` are never high together.

## Timing
Reset values:
- `GPIO_IN_DB`, `RISE`, `FALL`, `TICK` = 0.
- All counters and synchroniser flops = 0.
- Reset takes effect immediately when asserted. The first tick after release is `PRESCALE` cycles later.

Latency from a `RAW_IN` edge, with N = THRESH_eff and P = `PRESCALE`:
- Debounced mode: `SYNC_STAGES` + (N-1)·P + 1 to `SYNC_STAGES` + N·P cycles. The spread depends on tick phase.
- Bypass mode: `SYNC_STAGES` + 1 cycles.
- `GPIO_IN_DB[i]` and its `RISE[i]`/`FALL[i]` pulse change on the same clock edge.

Glitch rejection:
- A synchronised pulse shorter than (N-1)·P + 1 cycles is always rejected.
- A rejected glitch produces no event and leaves `cnt` at 0 once `sync` returns to `stable`.

Reset asserted mid-qualification:
- Discards all state.
- No pulse is emitted on reset or on its release.

## Test plan
All scenarios use `IO_NUM`=4, `SYNC_STAGES`=2, `PRESCALE`=4, `THRESH`=3, `EN`=1 unless stated.

1. Reset: hold `PRESETN`=0 with `RAW_IN`=4'hF → `GPIO_IN_DB`=0, `RISE`=`FALL`=0, `TICK`=0. After release, the first `TICK` appears exactly 4 cycles later.
2. Clean step: `RAW_IN[0]` 0→1 and held → `GPIO_IN_DB[0]` rises between 11 and 14 cycles after the edge. `RISE[0]` is high for exactly 1 cycle on that same edge, and `FALL` stays 0.
3. Glitch: `RAW_IN[1]` high for 6 cycles, then low → `GPIO_IN_DB[1]` stays 0, and no `RISE`/`FALL` pulse occurs. Repeat the test with 8 glitch start phases relative to `TICK`.
4. Bypass: `EN`=0, `RAW_IN`=4'b1010 → `GPIO_IN_DB`=4'b1010 exactly 3 cycles later, with `RISE[3]` and `RISE[1]` pulsing together for 1 cycle. `RAW_IN`=0 then → `FALL[3]` and `FALL[1]` pulse.
5. Simultaneous/independent: start from `GPIO_IN_DB`=4'b0100, then set `RAW_IN`=4'b0001 → `RISE[0]` and `FALL[2]` in the same cycle, and `GPIO_IN_DB`=4'b0001.
6. Reset mid-operation: assert `PRESETN` low after 2 ticks of mismatch on bit 0 → no event is emitted. After release with `RAW_IN[0]` still 1, the full 11–14 cycle qualification must elapse before `RISE[0]`.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// Synchronise and debounce board inputs for CoreGPIO GPIO_IN.
// Each bit is debounced against prescaled ticks and reports rise/fall events.
module gpio_in_debounce #(
  parameter int IO_NUM      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4,
  parameter int PRESCALE    = 100
) (
  input  logic                 SYSCLK_apb,
  input  logic                 PRESETN,
  input  logic                 EN,
  input  logic [IO_NUM-1:0]    RAW_IN,
  input  logic [CNT_WIDTH-1:0] THRESH,
  output logic [IO_NUM-1:0]    GPIO_IN_DB,
  output logic [IO_NUM-1:0]    RISE,
  output logic [IO_NUM-1:0]    FALL,
  output logic                 TICK
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST =
    PW'(PRESCALE - 1);

  logic [SYNC_STAGES-1:0][IO_NUM-1:0] sync_q;
  logic [IO_NUM-1:0] sync;

  logic [PW-1:0] pcnt;
  logic          tick;

  logic [IO_NUM-1:0]                stable, stable_n;
  logic [IO_NUM-1:0][CNT_WIDTH-1:0] cnt, cnt_n;
  logic [IO_NUM-1:0]                rise_q, rise_n;
  logic [IO_NUM-1:0]                fall_q, fall_n;
  logic [CNT_WIDTH:0]               thr_eff;

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RAW_IN};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  assign tick = EN && (pcnt == PLAST);

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      pcnt <= '0;
    end else if (!EN || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // zero threshold behaves as one tick
  assign thr_eff = (THRESH == '0) ?
    (CNT_WIDTH+1)'(1) : {1'b0, THRESH};

  always_comb begin
    stable_n = stable;
    cnt_n    = cnt;
    for (int i = 0; i < IO_NUM; i++) begin
      if (!EN) begin
        cnt_n[i]    = '0;
        stable_n[i] = sync[i];
      end else if (sync[i] == stable[i]) begin
        cnt_n[i] = '0;
      end else if (tick) begin
        if (({1'b0, cnt[i]} + (CNT_WIDTH+1)'(1))
            >= thr_eff) begin
          stable_n[i] = sync[i];
          cnt_n[i]    = '0;
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
    end
    rise_n = stable_n & ~stable;
    fall_n = ~stable_n & stable;
  end

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      stable <= '0;
      cnt    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      stable <= stable_n;
      cnt    <= cnt_n;
      rise_q <= rise_n;
      fall_q <= fall_n;
    end
  end

  assign GPIO_IN_DB = stable;
  assign RISE       = rise_q;
  assign FALL       = fall_q;
  assign TICK       = tick;

endmodule
